// File: rtl/i2c_init_seq_pkg.sv
// Shared types for the I2C register-initialisation sequencer: table entry
// layout, opcodes and failure codes.
package i2c_init_pkg;

  typedef enum logic [1:0] {
    OP_END          = 2'b00,
    OP_WRITE        = 2'b01,
    OP_WRITE_VERIFY = 2'b10,
    OP_DELAY        = 2'b11
  } op_e;

  localparam int unsigned OP_LSB  = 30;
  localparam int unsigned DEV_LSB = 23;
  localparam int unsigned REG_LSB = 15;
  localparam int unsigned DAT_LSB = 7;

  localparam logic [1:0] ERR_TIMEOUT  = 2'b00;
  localparam logic [1:0] ERR_DEV_NACK = 2'b01;
  localparam logic [1:0] ERR_REG_NACK = 2'b10;
  localparam logic [1:0] ERR_VERIFY   = 2'b11;

  typedef struct packed {
    op_e        op;
    logic [6:0] dev;
    logic [7:0] regaddr;
    logic [7:0] data;
  } entry_t;

  // Bits [6:0] of an entry are reserved, so only the used slice is taken.
  function automatic entry_t unpack_entry(input logic [31:7] w);
    entry_t e;
    e.op      = op_e'(w[OP_LSB +: 2]);
    e.dev     = w[DEV_LSB +: 7];
    e.regaddr = w[REG_LSB +: 8];
    e.data    = w[DAT_LSB +: 8];
    return e;
  endfunction

endpackage

// File: rtl/i2c_init_seq_if.sv
// Avalon-MM link between the init sequencer (master) and the I2C bridge (slave).
interface i2c_init_seq_if;
  logic        amm_waitrequest;
  logic        amm_write;
  logic        amm_read;
  logic [15:0] amm_address;
  logic [7:0]  amm_writedata;
  logic        amm_readdatavalid;
  logic [7:0]  amm_readdata;

  modport master (
    input  amm_waitrequest, amm_readdatavalid, amm_readdata,
    output amm_write, amm_read, amm_address, amm_writedata
  );

  modport slave (
    output amm_waitrequest, amm_readdatavalid, amm_readdata,
    input  amm_write, amm_read, amm_address, amm_writedata
  );
endinterface

// File: rtl/i2c_init_seq.sv
// Walks a register-init table and drives an Avalon-MM-to-I2C bridge:
// write, status check, optional read-back verify, retries and delays.
module i2c_init_seq
  import i2c_init_pkg::*;
#(
  parameter int unsigned ROM_AW     = 8,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned DELAY_UNIT = 50_000,
  parameter int unsigned RD_TIMEOUT = 2_000_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ROM_AW-1:0] err_index,
  output logic [1:0]        err_code,
  output logic [ROM_AW-1:0] table_addr,
  input  logic [31:0]       table_data,
  i2c_init_seq_if.master    amm
);

  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_WR, S_STAT_RD, S_STAT_WAIT,
    S_DAT_RD, S_DAT_WAIT, S_DELAY, S_NEXT, S_DONE, S_FAIL
  } state_e;

  state_e             state_q;
  logic [ROM_AW-1:0]  idx_q;
  logic [ROM_AW-1:0]  err_index_q;
  logic [RETRY_W-1:0] retry_q;
  logic [31:0]        cnt_q;
  entry_t             entry_q;
  logic               busy_q, done_q, error_q;
  logic               wr_q, rd_q, sel_q;
  logic [1:0]         err_code_q;

  entry_t      entry_d;
  logic        can_retry;
  logic        rd_timeout;
  logic [1:0]  stat_code;
  logic [31:0] delay_last;
  logic        unused_rsvd;

  assign entry_d     = unpack_entry(table_data[31:7]);
  assign unused_rsvd = ^table_data[6:0];
  assign can_retry   = (retry_q < RETRY_W'(MAX_RETRY));
  assign rd_timeout  = (cnt_q == RD_TIMEOUT - 1);
  assign stat_code   = amm.amm_readdata[1] ? ERR_REG_NACK : ERR_DEV_NACK;
  assign delay_last  = {24'b0, entry_q.data} * DELAY_UNIT - 32'd1;

  // Address and data come straight from the latched entry, which only changes
  // in DECODE, so they are stable for the whole life of any request.
  assign amm.amm_write     = wr_q;
  assign amm.amm_read      = rd_q;
  assign amm.amm_address   = {entry_q.dev, sel_q, entry_q.regaddr};
  assign amm.amm_writedata = entry_q.data;

  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign err_index  = err_index_q;
  assign err_code   = err_code_q;
  assign table_addr = idx_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      err_index_q <= '0;
      retry_q     <= '0;
      cnt_q       <= '0;
      entry_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      sel_q       <= 1'b0;
      err_code_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (start) begin
          idx_q   <= '0;
          retry_q <= '0;
          done_q  <= 1'b0;
          error_q <= 1'b0;
          busy_q  <= 1'b1;
          state_q <= S_FETCH;
        end
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          entry_q <= entry_d;
          cnt_q   <= '0;
          case (entry_d.op)
            OP_END:   state_q <= S_DONE;
            OP_DELAY: state_q <= (entry_d.data == 8'd0) ? S_NEXT : S_DELAY;
            default: begin
              wr_q    <= 1'b1;
              sel_q   <= 1'b0;
              state_q <= S_WR;
            end
          endcase
        end
        S_WR: if (!amm.amm_waitrequest) begin
          wr_q    <= 1'b0;
          rd_q    <= 1'b1;
          sel_q   <= 1'b1;
          state_q <= S_STAT_RD;
        end
        S_STAT_RD: if (!amm.amm_waitrequest) begin
          rd_q    <= 1'b0;
          cnt_q   <= '0;
          state_q <= S_STAT_WAIT;
        end
        S_STAT_WAIT: begin
          if (amm.amm_readdatavalid) begin
            cnt_q <= '0;
            if (amm.amm_readdata[1:0] != 2'b00) begin
              if (can_retry) begin
                retry_q <= retry_q + 1'b1;
                wr_q    <= 1'b1;
                sel_q   <= 1'b0;
                state_q <= S_WR;
              end else begin
                err_code_q <= stat_code;
                state_q    <= S_FAIL;
              end
            end else if (entry_q.op == OP_WRITE_VERIFY) begin
              rd_q    <= 1'b1;
              sel_q   <= 1'b0;
              state_q <= S_DAT_RD;
            end else begin
              state_q <= S_NEXT;
            end
          end else if (rd_timeout) begin
            err_code_q <= ERR_TIMEOUT;
            state_q    <= S_FAIL;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        S_DAT_RD: if (!amm.amm_waitrequest) begin
          rd_q    <= 1'b0;
          cnt_q   <= '0;
          state_q <= S_DAT_WAIT;
        end
        S_DAT_WAIT: begin
          if (amm.amm_readdatavalid) begin
            cnt_q <= '0;
            if (amm.amm_readdata == entry_q.data) begin
              state_q <= S_NEXT;
            end else if (can_retry) begin
              retry_q <= retry_q + 1'b1;
              wr_q    <= 1'b1;
              sel_q   <= 1'b0;
              state_q <= S_WR;
            end else begin
              err_code_q <= ERR_VERIFY;
              state_q    <= S_FAIL;
            end
          end else if (rd_timeout) begin
            err_code_q <= ERR_TIMEOUT;
            state_q    <= S_FAIL;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        S_DELAY: begin
          if (cnt_q == delay_last) state_q <= S_NEXT;
          else                     cnt_q   <= cnt_q + 32'd1;
        end
        S_NEXT: begin
          retry_q <= '0;
          // The last table slot is an implicit END; the index never wraps.
          if (idx_q == '1) begin
            state_q <= S_DONE;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= S_FETCH;
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        S_FAIL: begin
          error_q     <= 1'b1;
          err_index_q <= idx_q;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_init_seq.sv
// Scoreboard bench for i2c_init_seq: table ROM model, bridge model, and a
// monitor that checks every accepted Avalon request and every completion.
module tb_i2c_init_seq;
  import i2c_init_pkg::*;

  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, error;
  logic [AW-1:0] err_index, table_addr;
  logic [1:0]    err_code;
  logic [31:0]   table_data;

  i2c_init_seq_if bus ();

  i2c_init_seq #(
    .ROM_AW(AW), .MAX_RETRY(3), .DELAY_UNIT(10), .RD_TIMEOUT(40)
  ) dut (
    .clock(clk), .reset(rst), .start(start), .busy(busy), .done(done),
    .error(error), .err_index(err_index), .err_code(err_code),
    .table_addr(table_addr), .table_data(table_data), .amm(bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [7:0]  data;
    int          gap;
  } xact_t;

  typedef struct {
    bit          dn;
    bit          er;
    logic [AW-1:0] idx;
    logic [1:0]  code;
  } fin_t;

  xact_t       exp_q[$];
  fin_t        fin_q[$];
  logic [7:0]  rsp_q[$];
  logic [31:0] rom[1 << AW];

  int n_tests = 0;
  int n_fail  = 0;
  int rd_lat  = 2;
  int stall_arm = 0;
  int rd_acc  = 0;
  bit no_reply = 1'b0;

  task automatic chk(input bit ok, input string name, input string detail);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  function automatic logic [31:0] ent(input logic [1:0] op, input logic [6:0] dev,
                                      input logic [7:0] r, input logic [7:0] d);
    return {op, dev, r, d, 7'b0};
  endfunction

  task automatic exp_w(input logic [15:0] a, input logic [7:0] d, input int gap);
    xact_t x;
    x.wr = 1'b1; x.addr = a; x.data = d; x.gap = gap;
    exp_q.push_back(x);
  endtask

  task automatic exp_r(input logic [15:0] a, input int gap);
    xact_t x;
    x.wr = 1'b0; x.addr = a; x.data = 8'h00; x.gap = gap;
    exp_q.push_back(x);
  endtask

  task automatic exp_fin(input bit d, input bit e, input logic [AW-1:0] i, input logic [1:0] c);
    fin_t f;
    f.dn = d; f.er = e; f.idx = i; f.code = c;
    fin_q.push_back(f);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < (1 << AW); i++) rom[i] = ent(OP_END, 7'h0, 8'h0, 8'h0);
    rsp_q.delete();
  endtask

  task automatic run_seq(input string name, input int budget);
    int cyc;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk(busy === 1'b1, {name, "/busy_up"}, $sformatf("busy=%b required 1", busy));
    cyc = 0;
    while (busy === 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    chk(busy === 1'b0, {name, "/finish"}, $sformatf("busy=%b after %0d cycles required 0", busy, cyc));
    repeat (20) @(negedge clk);
    chk(exp_q.size() == 0, {name, "/drain"}, $sformatf("%0d requests missing, required 0", exp_q.size()));
    chk(fin_q.size() == 0, {name, "/fin_drain"}, $sformatf("%0d completions missing, required 0", fin_q.size()));
    exp_q.delete();
    fin_q.delete();
  endtask

  // Table ROM with one cycle of registered read latency.
  initial begin
    table_data = '0;
    forever begin
      @(posedge clk);
      table_data <= rom[table_addr];
    end
  end

  // Bridge model: optional write stall, read data returned rd_lat cycles after acceptance.
  initial begin
    int lat;
    int stall_left;
    logic [7:0] pend;
    lat = 0; stall_left = 0; pend = '0;
    bus.amm_waitrequest = 1'b0;
    bus.amm_readdatavalid = 1'b0;
    bus.amm_readdata = '0;
    forever begin
      @(negedge clk);
      bus.amm_readdatavalid = 1'b0;
      if (lat > 0) begin
        lat--;
        if (lat == 0) begin
          bus.amm_readdatavalid = 1'b1;
          bus.amm_readdata = pend;
        end
      end
      if (bus.amm_write && stall_left == 0 && stall_arm > 0) begin
        stall_left = stall_arm;
        stall_arm = 0;
      end
      if (stall_left > 0) begin
        bus.amm_waitrequest = 1'b1;
        stall_left--;
      end else begin
        bus.amm_waitrequest = 1'b0;
        if (bus.amm_read && !no_reply) begin
          lat = rd_lat;
          pend = (rsp_q.size() > 0) ? rsp_q.pop_front() : 8'h00;
        end
      end
    end
  end

  // Monitor: checks accepted requests against exp_q and completions against fin_q.
  initial begin
    bit holding, prev_busy, prev_rst, h_wr, ok;
    int idle, gap;
    logic [15:0] h_addr;
    logic [7:0] h_data;
    xact_t e;
    fin_t f;
    holding = 0; prev_busy = 0; prev_rst = 1; h_wr = 0;
    idle = 0; gap = 0; h_addr = '0; h_data = '0;
    forever begin
      @(negedge clk); #1;
      if (bus.amm_write || bus.amm_read) begin
        chk(!(bus.amm_write && bus.amm_read), "excl",
            $sformatf("write=%b read=%b, required never both", bus.amm_write, bus.amm_read));
        if (holding) begin
          chk(h_wr == bus.amm_write && h_addr == bus.amm_address && (!h_wr || h_data == bus.amm_writedata),
              "hold", $sformatf("wr=%b addr=%h data=%h, required wr=%b addr=%h data=%h",
              bus.amm_write, bus.amm_address, bus.amm_writedata, h_wr, h_addr, h_data));
        end else begin
          gap = idle;
          idle = 0;
        end
        if (bus.amm_waitrequest) begin
          holding = 1;
          h_wr = bus.amm_write;
          h_addr = bus.amm_address;
          h_data = bus.amm_writedata;
        end else begin
          holding = 0;
          if (bus.amm_read) rd_acc++;
          chk(exp_q.size() != 0, "xact_extra",
              $sformatf("unexpected wr=%b addr=%h data=%h, required no request",
              bus.amm_write, bus.amm_address, bus.amm_writedata));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            ok = (bus.amm_write == e.wr) && (bus.amm_address == e.addr) &&
                 (!e.wr || bus.amm_writedata == e.data) && (e.gap < 0 || gap == e.gap);
            chk(ok, "xact", $sformatf("wr=%b addr=%h data=%h gap=%0d, required wr=%b addr=%h data=%h gap=%0d",
                bus.amm_write, bus.amm_address, bus.amm_writedata, gap, e.wr, e.addr, e.data, e.gap));
          end
        end
      end else begin
        idle++;
        holding = 0;
      end
      if (prev_busy && !busy && !prev_rst) begin
        chk(fin_q.size() != 0, "fin_extra", $sformatf("done=%b error=%b, required no completion", done, error));
        if (fin_q.size() != 0) begin
          f = fin_q.pop_front();
          ok = (done == f.dn) && (error == f.er) && (!f.er || (err_index == f.idx && err_code == f.code));
          chk(ok, "fin", $sformatf("done=%b error=%b idx=%0d code=%b, required done=%b error=%b idx=%0d code=%b",
              done, error, err_index, err_code, f.dn, f.er, f.idx, f.code));
        end
      end
      prev_busy = busy;
      prev_rst = rst;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int base;
    clear_rom();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk({busy, done, error, err_index, err_code, table_addr, bus.amm_write, bus.amm_read} == '0 &&
        bus.amm_address == 16'h0 && bus.amm_writedata == 8'h0, "reset_state",
        $sformatf("busy=%b done=%b error=%b idx=%0d code=%b taddr=%0d wr=%b rd=%b addr=%h, required all 0",
        busy, done, error, err_index, err_code, table_addr, bus.amm_write, bus.amm_read, bus.amm_address));

    // Single WRITE, bridge ACKs.
    clear_rom();
    rom[0] = ent(OP_WRITE, 7'h50, 8'h10, 8'hA5);
    rsp_q.push_back(8'h00);
    exp_w(16'hA010, 8'hA5, -1); exp_r(16'hA110, 0);
    exp_fin(1, 0, 0, 2'b00);
    run_seq("write_ack", 200);

    // Device NACK on every attempt: 1 + 3 retries, then abort.
    clear_rom();
    rom[0] = ent(OP_WRITE, 7'h50, 8'h10, 8'hA5);
    repeat (4) rsp_q.push_back(8'h01);
    for (int i = 0; i < 4; i++) begin
      exp_w(16'hA010, 8'hA5, (i == 0) ? -1 : 2); exp_r(16'hA110, 0);
    end
    exp_fin(0, 1, 0, 2'b01);
    run_seq("dev_nack", 300);

    // Both error bits: register NACK wins.
    clear_rom();
    rom[0] = ent(OP_WRITE, 7'h50, 8'h10, 8'hA5);
    repeat (4) rsp_q.push_back(8'h03);
    for (int i = 0; i < 4; i++) begin
      exp_w(16'hA010, 8'hA5, (i == 0) ? -1 : 2); exp_r(16'hA110, 0);
    end
    exp_fin(0, 1, 0, 2'b10);
    run_seq("reg_nack_prio", 300);

    // WRITE_VERIFY: read-back 0x3D then 0x3C, one retry.
    clear_rom();
    rom[0] = ent(OP_WRITE_VERIFY, 7'h1A, 8'h22, 8'h3C);
    rsp_q.push_back(8'h00); rsp_q.push_back(8'h3D);
    rsp_q.push_back(8'h00); rsp_q.push_back(8'h3C);
    exp_w(16'h3422, 8'h3C, -1); exp_r(16'h3522, 0); exp_r(16'h3422, 2);
    exp_w(16'h3422, 8'h3C, 2);  exp_r(16'h3522, 0); exp_r(16'h3422, 2);
    exp_fin(1, 0, 0, 2'b00);
    run_seq("verify_retry", 300);

    // Verify mismatch on entry 1 every attempt.
    clear_rom();
    rom[0] = ent(OP_WRITE, 7'h50, 8'h10, 8'hA5);
    rom[1] = ent(OP_WRITE_VERIFY, 7'h1A, 8'h22, 8'h3C);
    rsp_q.push_back(8'h00);
    repeat (8) rsp_q.push_back(8'h00);
    exp_w(16'hA010, 8'hA5, -1); exp_r(16'hA110, 0);
    for (int i = 0; i < 4; i++) begin
      exp_w(16'h3422, 8'h3C, (i == 0) ? 5 : 2); exp_r(16'h3522, 0); exp_r(16'h3422, 2);
    end
    exp_fin(0, 1, 1, 2'b11);
    run_seq("verify_fail", 400);

    // Reset while waiting for status; the late response must be ignored.
    clear_rom();
    rom[0] = ent(OP_WRITE, 7'h50, 8'h10, 8'hA5);
    rd_lat = 10;
    rsp_q.push_back(8'h00);
    exp_w(16'hA010, 8'hA5, -1); exp_r(16'hA110, 0);
    base = rd_acc;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (rd_acc == base && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk(rd_acc != base, "rst_mid/status_read", $sformatf("reads accepted=%0d, required %0d", rd_acc - base, 1));
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk({busy, done, error, err_index, err_code, table_addr, bus.amm_write, bus.amm_read} == '0 &&
        bus.amm_address == 16'h0 && bus.amm_writedata == 8'h0, "rst_mid/outputs",
        $sformatf("busy=%b done=%b error=%b idx=%0d code=%b taddr=%0d wr=%b rd=%b addr=%h, required all 0",
        busy, done, error, err_index, err_code, table_addr, bus.amm_write, bus.amm_read, bus.amm_address));
    repeat (20) @(negedge clk);
    chk(busy == 1'b0 && done == 1'b0 && error == 1'b0, "rst_mid/late_rdv",
        $sformatf("busy=%b done=%b error=%b, required 0 0 0", busy, done, error));
    chk(exp_q.size() == 0, "rst_mid/drain", $sformatf("%0d requests missing, required 0", exp_q.size()));
    exp_q.delete();
    rd_lat = 2;
    rsp_q.push_back(8'h00);
    exp_w(16'hA010, 8'hA5, -1); exp_r(16'hA110, 0);
    exp_fin(1, 0, 0, 2'b00);
    run_seq("rst_restart", 200);

    // DELAY of 3 ticks x 10 cycles between two writes.
    clear_rom();
    rom[0] = ent(OP_WRITE, 7'h50, 8'h10, 8'hA5);
    rom[1] = ent(OP_DELAY, 7'h00, 8'h00, 8'd3);
    rom[2] = ent(OP_WRITE, 7'h50, 8'h11, 8'h5A);
    rsp_q.push_back(8'h00); rsp_q.push_back(8'h00);
    exp_w(16'hA010, 8'hA5, -1); exp_r(16'hA110, 0);
    exp_w(16'hA011, 8'h5A, 38); exp_r(16'hA111, 0);
    exp_fin(1, 0, 0, 2'b00);
    run_seq("delay", 300);

    // Write stalled by waitrequest for 100 cycles.
    clear_rom();
    rom[0] = ent(OP_WRITE, 7'h50, 8'h10, 8'hA5);
    stall_arm = 100;
    rsp_q.push_back(8'h00);
    exp_w(16'hA010, 8'hA5, -1); exp_r(16'hA110, 0);
    exp_fin(1, 0, 0, 2'b00);
    run_seq("stall", 400);

    // Full table with no END: stops after the last slot.
    clear_rom();
    for (int i = 0; i < (1 << AW); i++) begin
      rom[i] = ent(OP_WRITE, 7'(32'h20 + i), 8'(32'h40 + i), 8'(i * 17));
      rsp_q.push_back(8'h00);
      exp_w({7'(32'h20 + i), 1'b0, 8'(32'h40 + i)}, 8'(i * 17), (i == 0) ? -1 : 5);
      exp_r({7'(32'h20 + i), 1'b1, 8'(32'h40 + i)}, 0);
    end
    exp_fin(1, 0, 0, 2'b00);
    run_seq("implicit_end", 600);

    // No status response: timeout, no retry.
    clear_rom();
    rom[0] = ent(OP_WRITE, 7'h50, 8'h10, 8'hA5);
    no_reply = 1'b1;
    exp_w(16'hA010, 8'hA5, -1); exp_r(16'hA110, 0);
    exp_fin(0, 1, 0, 2'b00);
    run_seq("timeout", 300);
    no_reply = 1'b0;

    // start coinciding with reset is ignored.
    @(negedge clk); rst = 1'b1; start = 1'b1;
    @(negedge clk); rst = 1'b0; start = 1'b0;
    repeat (5) @(negedge clk);
    chk(busy == 1'b0 && error == 1'b0, "start_in_reset",
        $sformatf("busy=%b error=%b, required 0 0", busy, error));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_init_seq.md
# i2c_init_seq

Avalon-MM master that walks a register-initialisation table and drives the Avalon-MM-to-I2C bridge directly downstream of it. Each table entry is an I2C register write, a write with read-back verify, a delay, or end-of-table. After each write the block checks acknowledge status, retries failed entries, and reports pass/fail to the system controller. It brings up board peripherals such as video decoders, PMICs and clock synthesisers after reset, without CPU involvement.

## Interface
- `ROM_AW`, default 8: table address width; the table holds at most 2^ROM_AW entries.
- `MAX_RETRY`, default 3: number of extra attempts per entry after the first attempt fails.
- `DELAY_UNIT`, default 50_000: clock cycles per delay tick (1 ms at 50 MHz).
- `RD_TIMEOUT`, default 2_000_000: cycles to wait for `amm_readdatavalid` before declaring failure.
- `clock`, in, 1: single clock for the whole block.
- `reset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: one-cycle pulse; starts the sequence from entry 0. Ignored while `busy` is high.
- `busy`, out, 1: high from the cycle after `start` until `done` or `error` is set.
- `done`, out, 1: sticky; set when the sequence completes without error. Cleared by `start` or `reset`.
- `error`, out, 1: sticky; set when the sequence aborts. Cleared by `start` or `reset`.
- `err_index`, out, ROM_AW: index of the entry that failed. Valid while `error` is high.
- `err_code`, out, 2: failure cause. 01 = device NACK, 10 = register NACK, 11 = verify mismatch, 00 = read timeout.
- `table_addr`, out, ROM_AW: table read address.
- `table_data`, in, 32: table entry. Read latency is one cycle, registered inside the ROM.
- `amm_waitrequest`, in, 1: bridge stall.
- `amm_write`, out, 1: Avalon write request.
- `amm_read`, out, 1: Avalon read request.
- `amm_address`, out, 16: `[15:9]` = 7-bit device address, `[8]` = status select, `[7:0]` = register.
- `amm_writedata`, out, 8: write data.
- `amm_readdatavalid`, in, 1: read response valid.
- `amm_readdata`, in, 8: read data. When `[8]` = 1, the response is `{6'b0, reg_error, dev_error}`.

## Operation
- Entry format:
  - `[31:30]` = op: 00 END, 01 WRITE, 10 WRITE_VERIFY, 11 DELAY.
  - `[29:23]` = device address.
  - `[22:15]` = register.
  - `[14:7]` = data, or the tick count for DELAY.
  - `[6:0]` = reserved; ignored.
- State machine states: IDLE, FETCH, DECODE, WR, STAT_RD, STAT_WAIT, DAT_RD, DAT_WAIT, DELAY, NEXT, DONE, FAIL.
- Transitions:
  - IDLE goes to FETCH on `start`. It also clears the index, the retry counter, `done` and `error`.
  - FETCH drives `table_addr` = index and waits one cycle, then goes to DECODE.
  - DECODE dispatches on op: END goes to DONE; WRITE or WRITE_VERIFY go to WR; DELAY goes to DELAY.
  - WR issues a write with `[8]` = 0, then goes to STAT_RD.
  - STAT_RD issues a read with `[8]` = 1, same device and register, then goes to STAT_WAIT.
  - STAT_WAIT: if either error bit is set, retry or fail. Otherwise, a WRITE_VERIFY entry goes to DAT_RD and a WRITE entry goes to NEXT.
  - DAT_RD issues a read with `[8]` = 0, then goes to DAT_WAIT.
  - DAT_WAIT compares `amm_readdata` with the table data. Equal goes to NEXT; mismatch means retry or fail.
  - DELAY counts ticks × DELAY_UNIT cycles, then goes to NEXT. A tick count of 0 goes straight to NEXT.
  - NEXT increments the index and clears the retry counter. If the index was already 2^ROM_AW−1, it goes to DONE (implicit END, no wrap-around). Otherwise it goes to FETCH.
- Retry: if the retry counter is below MAX_RETRY, increment it and return to WR. Otherwise go to FAIL.
- Error codes:
  - `reg_error` takes priority over `dev_error` when both are set.
  - A read timeout goes to FAIL immediately with `err_code` 00, with no retry.
- DONE sets `done`; FAIL sets `error`, `err_index` and `err_code`. Both return to IDLE on the next cycle. `busy` goes low at the same edge the sticky flag sets.
- Reset mid-sequence:
  - All state returns to IDLE immediately and any held request is dropped.
  - A bridge read still in flight may later return `amm_readdatavalid`. Any `amm_readdatavalid` received outside STAT_WAIT/DAT_WAIT is ignored.

## Timing
- Reset values: all outputs are 0, and `table_addr` = 0.
- Avalon request rules:
  - `amm_write`/`amm_read`, address and data assert together and are held stable until the cycle in which `amm_waitrequest` is low. That cycle is the acceptance.
  - The request drops on the following edge.
  - At most one outstanding read at a time; never assert write and read together.
- The read timeout counter starts at acceptance and is cleared on `amm_readdatavalid`.
- Fixed overhead per WRITE entry outside bridge stalls: 3 cycles (FETCH, DECODE, NEXT).
- DELAY duration: exactly ticks × DELAY_UNIT cycles spent in DELAY.
- `start` arriving in the same cycle as `reset` is ignored.

## Structure
- Shared package `i2c_init_pkg` holds:
  - the opcode enum;
  - the entry field bit positions;
  - the `err_code` localparams.
- The table ROM is a separate sub-module, `i2c_init_rom`. It is a single-port registered ROM initialised from a `.mif` file, and is instanced by the integrator, not inside this block.
- Counters:
  - a retry counter of width `$clog2(MAX_RETRY+1)`;
  - a shared 32-bit counter for delay and timeout.

## Test plan
- Table {WRITE dev 0x50 reg 0x10 data 0xA5, END}, bridge model ACKs:
  - one write to address 0xA010 with data 0xA5, then a read of 0xA110 returning 0x00;
  - `done` = 1 and `busy` = 0, with no further requests.
- Same table, bridge returns status 0x01 four times: exactly 4 write/status pairs, then `error` = 1, `err_index` = 0, `err_code` = 01.
- WRITE_VERIFY data 0x3C, read-back 0x3D then 0x3C: one retry, then `done`; `error` stays 0.
- DELAY tick count 3 with DELAY_UNIT = 10: 30 cycles with no Avalon activity between entries.
- `amm_waitrequest` held high for 100 cycles during WR: request and address stay stable throughout, and the write is accepted exactly once.
- `reset` asserted in STAT_WAIT:
  - outputs return to reset values next cycle;
  - a late `amm_readdatavalid` is ignored;
  - a subsequent `start` restarts at entry 0.
